// File: rtl/fp_vec_checker.sv
// Test-vector sequencer for a two-operand ap_ctrl floating-point core.
// Reads operand/golden ROMs, launches the core per vector, compares bit-exact and reports mismatches.
module fp_vec_checker #(
    parameter int DATA_W  = 64,
    parameter int NUM_VEC = 20,
    parameter int ADDR_W  = 5,
    parameter int CNT_W   = 16,
    parameter int TMO_CYC = 1024
) (
    input  logic              ap_clk,
    input  logic              ap_rst_n,
    input  logic              ap_start,
    output logic              ap_done,
    output logic              ap_idle,
    output logic              ap_ready,
    output logic [CNT_W-1:0]  ap_return,
    input  logic              stop_on_fail,
    output logic [ADDR_W-1:0] first_fail,
    output logic              any_fail,
    output logic              timeout_seen,
    output logic [ADDR_W-1:0] rom_addr,
    output logic              rom_ce,
    input  logic [DATA_W-1:0] rom_a_q,
    input  logic [DATA_W-1:0] rom_b_q,
    input  logic [DATA_W-1:0] rom_z_q,
    output logic              core_start,
    input  logic              core_done,
    output logic [DATA_W-1:0] core_a,
    output logic [DATA_W-1:0] core_b,
    input  logic [DATA_W-1:0] core_result,
    output logic [6:0]        state_dbg
);

    // Handshake: ap_start is sampled only in IDLE; ap_done/ap_ready pulse together for one
    // cycle in DONE; core_start pulses once per vector and core_done is honoured only in WAIT.

    typedef enum logic [6:0] {
        S_IDLE   = 7'b0000001,
        S_FETCH  = 7'b0000010,
        S_LATCH  = 7'b0000100,
        S_LAUNCH = 7'b0001000,
        S_WAIT   = 7'b0010000,
        S_CHECK  = 7'b0100000,
        S_DONE   = 7'b1000000
    } state_t;

    localparam int                WD_W     = $clog2(TMO_CYC + 1);
    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_VEC - 1);
    localparam logic [WD_W-1:0]   WD_LAST  = WD_W'(TMO_CYC - 1);

    state_t            state, state_nxt;
    logic [ADDR_W-1:0] idx;
    logic [CNT_W-1:0]  count;
    logic [DATA_W-1:0] a_q, b_q, z_q, res_q;
    logic [WD_W-1:0]   wd;
    logic              miss;
    logic              stop_q;
    logic              mismatch;
    logic              end_run;
    logic              wd_expire;

    assign mismatch  = miss | (res_q != z_q);
    assign end_run   = (idx == LAST_IDX) | (mismatch & stop_q);
    assign wd_expire = (wd == WD_LAST);

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        rom_ce     = 1'b0;
        core_start = 1'b0;
        ap_done    = 1'b0;
        ap_ready   = 1'b0;
        ap_idle    = 1'b0;
        unique case (state)
            S_IDLE: begin
                ap_idle = ~ap_start;
                if (ap_start) state_nxt = S_FETCH;
            end
            S_FETCH: begin
                rom_ce    = 1'b1;
                state_nxt = S_LATCH;
            end
            S_LATCH:  state_nxt = S_LAUNCH;
            S_LAUNCH: begin
                core_start = 1'b1;
                state_nxt  = S_WAIT;
            end
            S_WAIT: begin
                // done takes priority over a watchdog expiry in the same cycle
                if (core_done || wd_expire) state_nxt = S_CHECK;
            end
            S_CHECK:  state_nxt = end_run ? S_DONE : S_FETCH;
            S_DONE: begin
                ap_done   = 1'b1;
                ap_ready  = 1'b1;
                state_nxt = S_IDLE;
            end
            default:  state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            idx          <= '0;
            count        <= '0;
            any_fail     <= 1'b0;
            timeout_seen <= 1'b0;
            first_fail   <= '0;
            stop_q       <= 1'b0;
            a_q          <= '0;
            b_q          <= '0;
            z_q          <= '0;
            res_q        <= '0;
            wd           <= '0;
            miss         <= 1'b0;
        end else begin
            unique case (state)
                S_IDLE: begin
                    if (ap_start) begin
                        idx          <= '0;
                        count        <= '0;
                        any_fail     <= 1'b0;
                        timeout_seen <= 1'b0;
                        stop_q       <= stop_on_fail;
                    end
                end
                S_LATCH: begin
                    a_q <= rom_a_q;
                    b_q <= rom_b_q;
                    z_q <= rom_z_q;
                end
                S_LAUNCH: begin
                    wd   <= '0;
                    miss <= 1'b0;
                end
                S_WAIT: begin
                    if (core_done) begin
                        res_q <= core_result;
                    end else if (wd_expire) begin
                        miss         <= 1'b1;
                        timeout_seen <= 1'b1;
                    end else begin
                        wd <= wd + 1'b1;
                    end
                end
                S_CHECK: begin
                    if (mismatch) begin
                        if (count != '1) count <= count + 1'b1;
                        if (!any_fail) begin
                            first_fail <= idx;
                            any_fail   <= 1'b1;
                        end
                    end
                    if (!end_run) idx <= idx + 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign ap_return = count;
    assign rom_addr  = idx;
    assign core_a    = a_q;
    assign core_b    = b_q;
    assign state_dbg = state;

endmodule

// File: tb/tb_fp_vec_checker.sv
// Bench for fp_vec_checker: ROM and core models, directed runs, scoreboard on ap_done.
module tb_fp_vec_checker;
    localparam int DATA_W  = 32;
    localparam int NUM_VEC = 5;
    localparam int ADDR_W  = 3;
    localparam int CNT_W   = 2;
    localparam int TMO_CYC = 8;
    localparam int EW      = 39;

    logic              ap_clk = 1'b0;
    logic              ap_rst_n = 1'b0;
    logic              ap_start = 1'b0;
    logic              ap_done, ap_idle, ap_ready;
    logic [CNT_W-1:0]  ap_return;
    logic              stop_on_fail = 1'b0;
    logic [ADDR_W-1:0] first_fail;
    logic              any_fail, timeout_seen;
    logic [ADDR_W-1:0] rom_addr;
    logic              rom_ce;
    logic [DATA_W-1:0] rom_a_q = '0, rom_b_q = '0, rom_z_q = '0;
    logic              core_start, core_done;
    logic [DATA_W-1:0] core_a, core_b, core_result;
    logic [6:0]        state_dbg;

    fp_vec_checker #(
        .DATA_W(DATA_W), .NUM_VEC(NUM_VEC), .ADDR_W(ADDR_W), .CNT_W(CNT_W), .TMO_CYC(TMO_CYC)
    ) dut (
        .ap_clk(ap_clk), .ap_rst_n(ap_rst_n), .ap_start(ap_start), .ap_done(ap_done),
        .ap_idle(ap_idle), .ap_ready(ap_ready), .ap_return(ap_return),
        .stop_on_fail(stop_on_fail), .first_fail(first_fail), .any_fail(any_fail),
        .timeout_seen(timeout_seen), .rom_addr(rom_addr), .rom_ce(rom_ce),
        .rom_a_q(rom_a_q), .rom_b_q(rom_b_q), .rom_z_q(rom_z_q),
        .core_start(core_start), .core_done(core_done), .core_a(core_a), .core_b(core_b),
        .core_result(core_result), .state_dbg(state_dbg)
    );

    // clock / reset / cycle counter
    always #5 ap_clk = ~ap_clk;
    int cyc = 0;
    always @(posedge ap_clk) cyc <= cyc + 1;

    // ROMs and core model (integer add stands in for the FP op; done 4 cycles after start)
    logic [DATA_W-1:0] rom_a [8];
    logic [DATA_W-1:0] rom_b [8];
    logic [DATA_W-1:0] rom_z [8];
    logic [DATA_W-1:0] gold  [8];
    logic [2:0]        core_cnt = '0;
    logic              hang_en = 1'b0;

    always @(posedge ap_clk) begin
        if (rom_ce) begin
            rom_a_q <= rom_a[rom_addr];
            rom_b_q <= rom_b[rom_addr];
            rom_z_q <= rom_z[rom_addr];
        end
        if (core_start) core_cnt <= 3'd4;
        else if (core_cnt != 0) core_cnt <= core_cnt - 3'd1;
    end
    assign core_done   = (core_cnt == 3'd1) && !(hang_en && rom_addr == 3'd2);
    assign core_result = core_a + core_b;

    // scoreboard
    int checks = 0;
    int errors = 0;
    logic [EW-1:0] exp_q[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(negedge ap_clk) begin
        if (ap_rst_n && ap_done) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done actual=1 expected=0 (cycle %0d)", cyc);
            end else begin
                logic [EW-1:0] e;
                e = exp_q.pop_front();
                chk("done_cycle", 32'(cyc), e[38:7]);
                chk("ap_ready", 32'(ap_ready), 32'd1);
                chk("ap_return", 32'(ap_return), 32'(e[1:0]));
                chk("any_fail", 32'(any_fail), 32'(e[5]));
                chk("timeout_seen", 32'(timeout_seen), 32'(e[6]));
                if (e[5]) chk("first_fail", 32'(first_fail), 32'(e[4:2]));
            end
        end
    end

    // driver
    task automatic set_golden(input logic [7:0] corrupt);
        for (int i = 0; i < 8; i++) rom_z[i] = gold[i] ^ {31'd0, corrupt[i]};
    endtask

    task automatic run_case(input logic stop, input int nruns, input int lat,
                            input logic [1:0] e_ret, input logic e_any,
                            input logic [2:0] e_first, input logic e_to);
        int s, seen, k;
        @(negedge ap_clk);
        stop_on_fail = stop;
        ap_start = 1'b1;
        s = cyc;
        for (int r = 0; r < nruns; r++)
            exp_q.push_back({32'(s + (r + 1) * lat + r), e_to, e_any, e_first, e_ret});
        seen = 0;
        k = 0;
        while (seen < nruns && k < 400) begin
            @(negedge ap_clk);
            k++;
            if (ap_done) seen++;
            if (nruns == 1 || seen >= nruns) ap_start = 1'b0;
        end
        ap_start = 1'b0;
        if (seen < nruns) begin
            checks++;
            errors++;
            $display("FAIL run_timeout actual=%0d expected=%0d dones", seen, nruns);
            exp_q.delete();
        end
        repeat (2) @(negedge ap_clk);
    endtask

    initial begin
        gold[0] = 32'h0000_0003; rom_a[0] = 32'h0000_0001; rom_b[0] = 32'h0000_0002;
        gold[1] = 32'h7f80_0000; rom_a[1] = 32'h3f80_0000; rom_b[1] = 32'h4000_0000;
        gold[2] = 32'h7fc0_0001; rom_a[2] = 32'h7fc0_0001; rom_b[2] = 32'h0000_0000;
        gold[3] = 32'h0000_0000; rom_a[3] = 32'hffff_ffff; rom_b[3] = 32'h0000_0001;
        gold[4] = 32'h2345_6789; rom_a[4] = 32'h1234_5678; rom_b[4] = 32'h1111_1111;
        for (int i = 5; i < 8; i++) begin
            gold[i] = '0; rom_a[i] = '0; rom_b[i] = '0;
        end
        set_golden(8'h00);

        repeat (3) @(negedge ap_clk);
        chk("rst_ap_done", 32'(ap_done), 32'd0);
        chk("rst_ap_idle", 32'(ap_idle), 32'd1);
        chk("rst_ap_return", 32'(ap_return), 32'd0);
        chk("rst_flags", 32'({any_fail, timeout_seen, first_fail}), 32'd0);
        chk("rst_core_start", 32'(core_start), 32'd0);
        ap_rst_n = 1'b1;
        @(negedge ap_clk);

        // all pass: 5 vectors * 8 cycles + 1
        run_case(1'b0, 1, 41, 2'd0, 1'b0, 3'd0, 1'b0);
        chk("idle_after_run", 32'(ap_idle), 32'd1);
        // Z[1], Z[3] corrupted, run to completion
        set_golden(8'b0000_1010);
        run_case(1'b0, 1, 41, 2'd2, 1'b1, 3'd1, 1'b0);
        chk("hold_ap_return", 32'(ap_return), 32'd2);
        chk("hold_first_fail", 32'(first_fail), 32'd1);
        // same, stop at first fail: done right after vector 1 check
        run_case(1'b1, 1, 17, 2'd1, 1'b1, 3'd1, 1'b0);
        // NaN payload differing in one bit must count as a mismatch
        set_golden(8'b0000_0100);
        run_case(1'b0, 1, 41, 2'd1, 1'b1, 3'd2, 1'b0);
        // core hangs on vector 2: watchdog adds 4 cycles to that vector
        set_golden(8'h00);
        hang_en = 1'b1;
        run_case(1'b0, 1, 45, 2'd1, 1'b1, 3'd2, 1'b1);
        run_case(1'b1, 1, 29, 2'd1, 1'b1, 3'd2, 1'b1);
        hang_en = 1'b0;

        // reset asserted during WAIT of vector 1
        begin
            int s;
            @(negedge ap_clk);
            ap_start = 1'b1;
            s = cyc;
            @(negedge ap_clk);
            ap_start = 1'b0;
            while (cyc < s + 13) @(negedge ap_clk);
            chk("pre_abort_rom_addr", 32'(rom_addr), 32'd1);
            ap_rst_n = 1'b0;
            #1;
            chk("abort_core_a", core_a, 32'd0);
            chk("abort_rom_addr", 32'(rom_addr), 32'd0);
            chk("abort_outputs", 32'({ap_return, any_fail, timeout_seen, first_fail}), 32'd0);
            chk("abort_idle", 32'(ap_idle), 32'd1);
            repeat (2) @(negedge ap_clk);
            ap_rst_n = 1'b1;
            repeat (10) @(negedge ap_clk);
            chk("abort_state_idle", 32'(state_dbg), 32'd1);
        end
        run_case(1'b0, 1, 41, 2'd0, 1'b0, 3'd0, 1'b0);

        // every vector fails, counter saturates; start held for two back-to-back runs
        set_golden(8'b0001_1111);
        run_case(1'b0, 2, 41, 2'd3, 1'b1, 3'd0, 1'b0);
        chk("final_idle", 32'(ap_idle), 32'd1);
        chk("final_queue_empty", 32'(exp_q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        errors++;
        $display("FAIL global_timeout actual=%0d expected=done cycles", cyc);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $fatal(1, "global timeout");
    end
endmodule
